// File: rtl/morse_pkg.sv
// Constants shared by the Morse digit decoder and the display scanner.
package morse_pkg;

  localparam logic [1:0] ST_BUSY = 2'b00;
  localparam logic [1:0] ST_IDLE = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic [1:0] ST_ERR  = 2'b11;

  localparam logic [6:0] SEG_BLANK   = 7'b0000000;
  localparam int         DISP_DIGITS = 4;

endpackage

// File: rtl/scan_timer.sv
// Free-running digit-slot timer: prescaler of SCAN_DIV clocks and a 2-bit slot index.
module scan_timer
  import morse_pkg::*;
#(
  parameter int SCAN_DIV = 12_500
) (
  input  logic       C,
  input  logic       nR,
  output logic [1:0] idx,
  output logic       tick
);

  localparam int               PRE_W   = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0] preCnt_r;
  logic [1:0]       idx_r;

  assign tick = (preCnt_r == PRE_MAX);
  assign idx  = idx_r;

  // Prescaler wraps at SCAN_DIV-1 and advances the slot index on the wrap.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      preCnt_r <= {PRE_W{1'b0}};
      idx_r    <= 2'd0;
    end else if (tick) begin
      preCnt_r <= {PRE_W{1'b0}};
      idx_r    <= idx_r + 2'd1;
    end else begin
      preCnt_r <= preCnt_r + PRE_W'(1);
      idx_r    <= idx_r;
    end
  end

endmodule

// File: rtl/morse_display_scan.sv
// Captures completed Morse digits into a 4-deep history and multiplexes them
// onto a 4-position 7-segment display.
module morse_display_scan
  import morse_pkg::*;
#(
  parameter int SCAN_DIV = 12_500
) (
  input  logic       C,
  input  logic       nR,
  input  logic [6:0] ABCDEFGY,
  input  logic [1:0] StatusY,
  input  logic       CLR,
  output logic [6:0] SegY,
  output logic [3:0] DigY,
  output logic       ErrY,
  output logic [2:0] CntY
);

  logic       doneQ_r;
  logic       capQ_r;
  logic [1:0] statQ_r;
  logic [6:0] segIn_r;
  logic [6:0] digBuf_r [DISP_DIGITS];
  logic [2:0] cnt_r;
  logic       err_r;
  logic [1:0] idx_s;
  logic       unusedTick_s;
  logic       cap_s;

  // doneQ resets high so a status already done at reset release is ignored.
  assign cap_s = StatusY[1] & ~doneQ_r;

  scan_timer #(.SCAN_DIV(SCAN_DIV)) uTimer (
    .C    (C),
    .nR   (nR),
    .idx  (idx_s),
    .tick (unusedTick_s)
  );

  // Sample the decoder and register the capture event; CLR in the event cycle drops it.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      doneQ_r <= 1'b1;
      capQ_r  <= 1'b0;
      statQ_r <= ST_BUSY;
      segIn_r <= SEG_BLANK;
    end else begin
      doneQ_r <= StatusY[1];
      capQ_r  <= cap_s & ~CLR;
      statQ_r <= StatusY;
      segIn_r <= ABCDEFGY;
    end
  end

  // Digit history (newest at index 0), valid count and sticky error flag.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      for (int i = 0; i < DISP_DIGITS; i++) digBuf_r[i] <= SEG_BLANK;
      cnt_r <= 3'd0;
      err_r <= 1'b0;
    end else if (CLR) begin
      for (int i = 0; i < DISP_DIGITS; i++) digBuf_r[i] <= SEG_BLANK;
      cnt_r <= 3'd0;
      err_r <= 1'b0;
    end else if (capQ_r) begin
      case (statQ_r)
        ST_DONE: begin
          digBuf_r[3] <= digBuf_r[2];
          digBuf_r[2] <= digBuf_r[1];
          digBuf_r[1] <= digBuf_r[0];
          digBuf_r[0] <= segIn_r;
          cnt_r       <= (cnt_r == 3'(DISP_DIGITS)) ? cnt_r : cnt_r + 3'd1;
        end
        ST_ERR:  err_r <= 1'b1;
        default: err_r <= err_r;
      endcase
    end else begin
      cnt_r <= cnt_r;
      err_r <= err_r;
    end
  end

  // Drive the active slot only when it holds a valid digit; otherwise blank everything.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      SegY <= SEG_BLANK;
      DigY <= 4'b0000;
    end else if ({1'b0, idx_s} < cnt_r) begin
      SegY <= digBuf_r[idx_s];
      DigY <= 4'b0001 << idx_s;
    end else begin
      SegY <= SEG_BLANK;
      DigY <= 4'b0000;
    end
  end

  assign ErrY = err_r;
  assign CntY = cnt_r;

endmodule

// File: tb/tb_morse_display_scan.sv
// Randomized self-checking bench for morse_display_scan against a queue-based reference model.
module tb_morse_display_scan;
  import morse_pkg::*;

  localparam int SD = 4;

  logic       C        = 1'b0;
  logic       nR       = 1'b0;
  logic [6:0] ABCDEFGY = 7'b0000000;
  logic [1:0] StatusY  = 2'b00;
  logic       CLR      = 1'b0;
  logic [6:0] SegY;
  logic [3:0] DigY;
  logic       ErrY;
  logic [2:0] CntY;

  int errCnt = 0;
  int chkCnt = 0;

  morse_display_scan #(.SCAN_DIV(SD)) dut (
    .C        (C),
    .nR       (nR),
    .ABCDEFGY (ABCDEFGY),
    .StatusY  (StatusY),
    .CLR      (CLR),
    .SegY     (SegY),
    .DigY     (DigY),
    .ErrY     (ErrY),
    .CntY     (CntY)
  );

  always #5 C = ~C;

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: newest digit at the front of the queue, slot index from elapsed cycles.
  logic [6:0] mQ [$];
  bit         mErr      = 1'b0;
  bit         mDoneQ    = 1'b1;
  bit         mPend     = 1'b0;
  bit         mPendErr  = 1'b0;
  logic [6:0] mPendData = 7'b0000000;
  int         mN        = 0;
  logic [6:0] expSeg    = 7'b0000000;
  logic [3:0] expDig    = 4'b0000;

  always @(posedge C or negedge nR) begin
    int slot;
    if (!nR) begin
      mQ.delete();
      mErr = 1'b0; mDoneQ = 1'b1; mPend = 1'b0; mN = 0;
      expSeg = 7'b0000000; expDig = 4'b0000;
    end else begin
      slot = (mN / SD) % 4;
      if (slot < mQ.size()) begin
        expDig = 4'(1 << slot);
        expSeg = mQ[slot];
      end else begin
        expDig = 4'b0000;
        expSeg = 7'b0000000;
      end
      if (CLR) begin
        mQ.delete();
        mErr = 1'b0;
      end else if (mPend) begin
        if (mPendErr) mErr = 1'b1;
        else begin
          mQ.push_front(mPendData);
          if (mQ.size() > 4) void'(mQ.pop_back());
        end
      end
      mPend     = StatusY[1] && !mDoneQ && !CLR;
      mPendErr  = StatusY[0];
      mPendData = ABCDEFGY;
      mDoneQ    = StatusY[1];
      mN++;
    end
  end

  always @(negedge C) begin
    checkVal("seg", 16'(SegY), 16'(expSeg));
    checkVal("dig", 16'(DigY), 16'(expDig));
    checkVal("cnt", 16'(CntY), 16'(mQ.size()));
    checkVal("err", 16'(ErrY), 16'(mErr));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge C);
      #1;
    end
  endtask

  task automatic sendSym(input logic [6:0] data, input logic [1:0] st, input int hold);
    StatusY = ST_BUSY;
    step(2);
    ABCDEFGY = data;
    StatusY  = st;
    step(hold);
    StatusY = ST_BUSY;
    step(1);
  endtask

  task automatic waitDig(input int j, input logic [6:0] segExp, input string tag);
    bit found = 1'b0;
    for (int t = 0; t < 64 && !found; t++) begin
      if (DigY == 4'(1 << j)) found = 1'b1;
      else step(1);
    end
    checkVal({tag, "_slot"}, 16'(found), 16'd1);
    if (found) checkVal(tag, 16'(SegY), 16'(segExp));
  endtask

  logic [6:0] codes [5] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};

  initial begin
    // Reset and blank frame
    step(3);
    nR = 1'b1;
    step(16);
    checkVal("blankCnt", 16'(CntY), 16'd0);
    checkVal("blankDig", 16'(DigY), 16'd0);

    // Single digit with capture latency
    StatusY = ST_BUSY;
    step(2);
    ABCDEFGY = codes[1];
    StatusY  = ST_DONE;
    step(1);
    checkVal("lat0", 16'(CntY), 16'd0);
    step(1);
    checkVal("lat1", 16'(CntY), 16'd1);
    step(1);
    StatusY = ST_BUSY;
    waitDig(0, codes[1], "single");
    step(SD);
    checkVal("singleIdx1", 16'(DigY), 16'd0);

    // Overflow keeps the four newest digits
    CLR = 1'b1; step(1); CLR = 1'b0;
    for (int i = 0; i < 5; i++) sendSym(codes[i], ST_DONE, 2);
    checkVal("ovfCnt", 16'(CntY), 16'd4);
    for (int j = 0; j < 4; j++) waitDig(j, codes[4 - j], "ovfSeg");

    // Error capture leaves buffer alone, sticky across valid captures
    CLR = 1'b1; step(1); CLR = 1'b0;
    sendSym(codes[1], ST_DONE, 2);
    sendSym(codes[2], ST_DONE, 2);
    sendSym(7'b1111111, ST_ERR, 2);
    checkVal("errFlag", 16'(ErrY), 16'd1);
    checkVal("errCnt", 16'(CntY), 16'd2);
    waitDig(1, codes[1], "errBuf");
    sendSym(codes[3], ST_DONE, 2);
    checkVal("errSticky", 16'(ErrY), 16'd1);
    checkVal("errCnt3", 16'(CntY), 16'd3);

    // CLR on the capture edge drops the symbol
    StatusY = ST_BUSY;
    step(2);
    ABCDEFGY = codes[4];
    StatusY  = ST_DONE;
    CLR      = 1'b1;
    step(1);
    CLR = 1'b0;
    step(6);
    checkVal("clrCnt", 16'(CntY), 16'd0);
    checkVal("clrErr", 16'(ErrY), 16'd0);
    StatusY = ST_BUSY;
    step(1);

    // Reset released while done is pending
    nR = 1'b0;
    StatusY = ST_DONE;
    step(2);
    nR = 1'b1;
    step(6);
    checkVal("pendCnt", 16'(CntY), 16'd0);
    sendSym(codes[0], ST_DONE, 3);
    checkVal("pendCnt1", 16'(CntY), 16'd1);

    // Asynchronous reset mid-frame
    sendSym(codes[2], ST_DONE, 2);
    sendSym(codes[3], ST_ERR, 2);
    @(posedge C);
    #2 nR = 1'b0;
    #1;
    checkVal("arstCnt", 16'(CntY), 16'd0);
    checkVal("arstErr", 16'(ErrY), 16'd0);
    checkVal("arstDig", 16'(DigY), 16'd0);
    checkVal("arstSeg", 16'(SegY), 16'd0);
    step(2);
    nR = 1'b1;

    // Random symbol stream including idle gaps, 10<->11 flips and CLR pulses
    for (int n = 0; n < 300; n++) begin
      StatusY = ($urandom_range(0, 1) == 1) ? ST_IDLE : ST_BUSY;
      step($urandom_range(1, 3));
      ABCDEFGY = 7'($urandom);
      StatusY  = ($urandom_range(0, 4) == 0) ? ST_ERR : ST_DONE;
      CLR      = ($urandom_range(0, 15) == 0);
      step(1);
      CLR = 1'b0;
      if ($urandom_range(0, 5) == 0) StatusY = StatusY ^ 2'b01;
      step($urandom_range(1, 4));
    end
    StatusY = ST_BUSY;
    step(20);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
